predicate_writeback_queue: RTL and testbench
============================================

# predicate_writeback_queue

Buffers per-lane predicate results from the compare/set-predicate execution units and issues them in order to the single write port of `predicate_register_block`. It sits directly upstream of that block. It also arbitrates with the read path for the shared `warp_selector`, and it exposes a pending-write lookup so the issue scoreboard can stall reads of predicates that have not yet been written.

## Interface
Parameters:
- `NUM_LANES`, 8: lanes per warp; width of the mask and data vectors.
- `NUM_PREGS`, 64: predicate registers per warp; `waddr` width = $clog2(NUM_PREGS) = 6.
- `NUM_WARPS`, 8: warps; warp field width = $clog2(NUM_WARPS) = 3.
- `DEPTH`, 4: queue entries; power of two, ≥2.

Ports:
- `clk`, in, 1: clock.
- `rst_n`, in, 1: reset, asynchronous, active-low. One clock domain; reset is asynchronous and active-low.
- `in_valid`, in, 1: a predicate result is presented.
- `in_ready`, out, 1: the queue accepts the result.
- `in_warp`, in, 3: warp of the result.
- `in_addr`, in, 6: destination predicate register.
- `in_lane_mask`, in, 8: lanes to write.
- `in_data`, in, 8: predicate value per lane.
- `wb_req`, out, 1: request for the shared `warp_selector` mux.
- `wb_gnt`, in, 1: grant from the warp-selector arbiter. Valid only while `wb_req` is high.
- `wb_warp`, out, 3: warp of the head entry; drives `warp_selector` when granted.
- `write_en`, out, 8: per-lane write enable to `predicate_register_block`.
- `waddr`, out, 6: write address.
- `wdata`, out, 8: write data. Bit i connects to `wdata_i` at the top level.
- `hz_warp`, in, 3: scoreboard lookup, warp.
- `hz_addr`, in, 6: scoreboard lookup, register.
- `hz_hit`, out, 1: a queued entry matches (`hz_warp`, `hz_addr`).
- `count`, out, $clog2(DEPTH)+1: occupancy.

## Operation
- Circular FIFO with `DEPTH` entries. Each entry holds {warp, addr, mask, data}.
- The queue uses read and write pointers that are `$clog2(DEPTH)` bits wide. The pointers wrap naturally.
- Full and empty are derived from `count`.
- Enqueue condition: `in_valid && in_ready`.
  - If `in_lane_mask == 0`, the handshake completes but nothing is stored.
- `in_ready = (count != DEPTH)`.
  - `in_ready` is registered-state only and never depends on the pop in the same cycle.
  - When the queue is full and the head pops, `in_ready` stays low that cycle.
- `wb_req = (count != 0)`.
- `wb_warp`, `waddr` and `wdata` always show the head entry. They are don't-care when the queue is empty.
- `write_en = (wb_req && wb_gnt) ? head.mask : 8'h00`. This is the only combinational path from `wb_gnt`.
- Pop condition: `wb_req && wb_gnt`. The register block commits the write on the same rising edge.
- Simultaneous push and pop: `count` is unchanged and both pointers advance.
- `hz_hit` is the OR over all valid entries of (warp == `hz_warp` && addr == `hz_addr`).
  - It is purely combinational.
  - The head entry still counts during its pop cycle.
  - An entry being pushed in the current cycle does not count.
- Writes retire strictly in order. Two entries with the same address are both written, and the later one wins.
- No merging and no bypass.

## Timing
- Reset (asynchronous assert, synchronous deassert upstream):
  - pointers = 0, `count` = 0, `wb_req` = 0, `write_en` = 0, `in_ready` = 1, `hz_hit` = 0.
  - Entry storage is not reset.
- Reset asserted mid-operation discards all entries immediately. No partial write is issued, because `write_en` falls with `wb_req`.
- Minimum latency:
  - Result accepted at edge T.
  - `wb_req` is high in the cycle after T.
  - With `wb_gnt` high in that cycle, the register file is written at edge T+1.
  - The data is readable from `predicate_register_block` in the cycle after T+1.
- Sustained throughput is one write per cycle while `wb_gnt` is held.
- Once raised, `wb_req` stays high until the pop. `wb_warp` is stable while `wb_req` is high and no pop has occurred.
- `wb_gnt` low stalls the queue indefinitely without losing data.

## Structure
- Package `predicate_pkg`:
  - `NUM_LANES`, `NUM_PREGS`, `NUM_WARPS` and the derived widths.
  - Typedefs `pred_addr_t`, `warp_id_t`, `lane_vec_t`.
  - `pwb_entry_t` struct {warp, addr, mask, data}.
- One sub-module, `pwb_fifo`: a generic parameterised entry storage with pointer/count logic. It exports all entries and valid bits for the hazard compare.
- The top level adds the zero-mask drop, the request/grant gating and the hazard compare.

## Test plan
- Single write: push warp 3, addr 6'h2A, mask 8'hFF, data 8'hA5 with `wb_gnt` tied high.
  - `write_en` = 8'hFF and `waddr` = 6'h2A one cycle later, for exactly one cycle.
  - A port-0 read of warp 3, addr 6'h2A then returns bits 10100101 on lanes 0–7.
- Backpressure: `wb_gnt` = 0, push 5 results.
  - `in_ready` falls after the 4th (`count` = 4); the 5th is held.
  - Raise `wb_gnt`: four writes follow in push order, then the 5th.
- Simultaneous push/pop at full: `count` stays 4 and `in_ready` stays 0 in that cycle.
  - After the pop, ordering is intact across pointer wrap: 8 pushes give 8 in-order writes.
- Partial mask: mask 8'h0F, data 8'hFF over a register preloaded with 8'h00.
  - Readback is 8'h0F; lanes 4–7 are untouched.
  - A push with mask 8'h00 completes the handshake and produces no `wb_req`.
- Hazard: queue (warp 1, 6'h05) and hold `wb_gnt` = 0.
  - Lookup (1, 6'h05) gives `hz_hit` = 1.
  - Lookups (2, 6'h05) and (1, 6'h06) give 0.
  - After the pop edge, (1, 6'h05) gives 0.
- Reset mid-stream: 3 entries queued, then `rst_n` pulsed low between edges.
  - `wb_req`, `write_en` and `count` go to 0 immediately.
  - No stale writes appear after release.

Source files
------------

// File: rtl/predicate_pkg.sv
// Purpose: shared widths, types and the queue entry layout for the predicate writeback path.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
package predicate_pkg;

  localparam int NUM_LANES = 8;
  localparam int NUM_PREGS = 64;
  localparam int NUM_WARPS = 8;

  localparam int ADDR_W = $clog2(NUM_PREGS);
  localparam int WARP_W = $clog2(NUM_WARPS);

  typedef logic [ADDR_W-1:0]    pred_addr_t;
  typedef logic [WARP_W-1:0]    warp_id_t;
  typedef logic [NUM_LANES-1:0] lane_vec_t;

  typedef struct packed {
    warp_id_t   warp;
    pred_addr_t addr;
    lane_vec_t  mask;
    lane_vec_t  data;
  } pwb_entry_t;

  localparam int ENTRY_W = $bits(pwb_entry_t);

  // True when a queued entry targets the given warp/register pair.
  function automatic logic entry_matches(pwb_entry_t e, warp_id_t w, pred_addr_t a);
    return (e.warp == w) && (e.addr == a);
  endfunction

endpackage

// File: rtl/pwb_fifo.sv
// Purpose: generic circular entry store with pointer/count bookkeeping; exposes every slot for lookups.
// Latency: pushed word is visible at the head on the cycle after the push edge.
// Backpressure: pushes while full and pops while empty are ignored; the caller gates on count.
module pwb_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              push,
  input  logic [WIDTH-1:0]                  push_data,
  input  logic                              pop,
  output logic [WIDTH-1:0]                  head_data,
  output logic [$clog2(DEPTH):0]            count,
  output logic [DEPTH-1:0][WIDTH-1:0]       entries,
  output logic [DEPTH-1:0]                  entry_vld
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [AW-1:0]               wr_ptr;
  logic [AW-1:0]               rd_ptr;
  logic                        do_push;
  logic                        do_pop;
  logic [AW-1:0]               offs [DEPTH];

  assign do_push = push && (count != CW'(DEPTH));
  assign do_pop  = pop && (count != '0);

  // Entry storage carries no reset; only the bookkeeping decides what is live.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally at DEPTH; count tracks occupancy including push+pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign head_data = mem[rd_ptr];
  assign entries   = mem;

  // A slot is live when its distance from the read pointer is below the occupancy.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      offs[i]      = AW'(i) - rd_ptr;
      entry_vld[i] = ({1'b0, offs[i]} < count);
    end
  end

endmodule

// File: rtl/predicate_writeback_queue.sv
// Purpose: in-order queue of per-lane predicate results feeding the single predicate register write port.
// Latency: accepted at edge T, request high in cycle T..T+1, written at edge T+1 when granted.
// Backpressure: in_ready drops at DEPTH entries (registered state only); wb_gnt low stalls without loss.
module predicate_writeback_queue
  import predicate_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WARP_W-1:0]         in_warp,
  input  logic [ADDR_W-1:0]         in_addr,
  input  logic [NUM_LANES-1:0]      in_lane_mask,
  input  logic [NUM_LANES-1:0]      in_data,
  output logic                      wb_req,
  input  logic                      wb_gnt,
  output logic [WARP_W-1:0]         wb_warp,
  output logic [NUM_LANES-1:0]      write_en,
  output logic [ADDR_W-1:0]         waddr,
  output logic [NUM_LANES-1:0]      wdata,
  input  logic [WARP_W-1:0]         hz_warp,
  input  logic [ADDR_W-1:0]         hz_addr,
  output logic                      hz_hit,
  output logic [$clog2(DEPTH):0]    count
);

  localparam int CW = $clog2(DEPTH) + 1;

  pwb_entry_t                    in_entry;
  pwb_entry_t                    head;
  logic [ENTRY_W-1:0]            head_data;
  logic [DEPTH-1:0][ENTRY_W-1:0] entries;
  logic [DEPTH-1:0]              entry_vld;
  logic                          push;
  logic                          pop;

  // Ready looks only at stored occupancy, so a full queue stays closed even while popping.
  assign in_ready = (count != CW'(DEPTH));
  assign wb_req   = (count != '0);

  // A zero mask writes nothing, so it is acknowledged but never stored.
  assign push = in_valid && in_ready && (in_lane_mask != '0);
  assign pop  = wb_req && wb_gnt;

  assign in_entry = '{warp: in_warp, addr: in_addr, mask: in_lane_mask, data: in_data};

  pwb_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (in_entry),
    .pop       (pop),
    .head_data (head_data),
    .count     (count),
    .entries   (entries),
    .entry_vld (entry_vld)
  );

  assign head    = pwb_entry_t'(head_data);
  assign wb_warp = head.warp;
  assign waddr   = head.addr;
  assign wdata   = head.data;

  // The grant is the only combinational input to the write enables; the head commits on this edge.
  assign write_en = pop ? head.mask : '0;

  // Any live entry (the popping head included) targeting the looked-up register flags a hazard.
  always_comb begin
    hz_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entry_vld[i] && entry_matches(pwb_entry_t'(entries[i]), hz_warp, hz_addr)) hz_hit = 1'b1;
    end
  end

endmodule

// File: tb/tb_predicate_writeback_queue.sv
// Purpose: self-checking bench; queue model plus a register-file stand-in fed by the DUT write port.
// Latency: n/a.
// Backpressure: n/a.
module tb_predicate_writeback_queue;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [2:0] in_warp = '0;
  logic [5:0] in_addr = '0;
  logic [7:0] in_lane_mask = '0;
  logic [7:0] in_data = '0;
  logic       wb_req;
  logic       wb_gnt = 1'b0;
  logic [2:0] wb_warp;
  logic [7:0] write_en;
  logic [5:0] waddr;
  logic [7:0] wdata;
  logic [2:0] hz_warp = '0;
  logic [5:0] hz_addr = '0;
  logic       hz_hit;
  logic [2:0] count;

  always #5 clk = ~clk;

  predicate_writeback_queue #(.DEPTH(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_warp      (in_warp),
    .in_addr      (in_addr),
    .in_lane_mask (in_lane_mask),
    .in_data      (in_data),
    .wb_req       (wb_req),
    .wb_gnt       (wb_gnt),
    .wb_warp      (wb_warp),
    .write_en     (write_en),
    .waddr        (waddr),
    .wdata        (wdata),
    .hz_warp      (hz_warp),
    .hz_addr      (hz_addr),
    .hz_hit       (hz_hit),
    .count        (count)
  );

  typedef struct {
    logic [2:0] w;
    logic [5:0] a;
    logic [7:0] m;
    logic [7:0] d;
  } ent_t;

  int   tests = 0;
  int   fails = 0;
  ent_t mq[$];       // model queue contents
  ent_t wlog[$];     // writes observed on the DUT write port
  logic [7:0] rf [8][64];
  bit   m_full;
  bit   m_hit;
  logic [7:0] m_wen;
  ent_t e_tmp;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [2:0] w, input logic [5:0] a, input logic [7:0] m, input logic [7:0] d);
    in_valid = 1'b1; in_warp = w; in_addr = a; in_lane_mask = m; in_data = d;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Model: FIFO of non-empty-mask results, capacity 4, head leaves on every granted cycle.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
    end else begin
      m_full = (mq.size() == 4);
      if (mq.size() > 0 && wb_gnt) void'(mq.pop_front());
      if (in_valid && !m_full && in_lane_mask != 8'h00) begin
        e_tmp.w = in_warp; e_tmp.a = in_addr; e_tmp.m = in_lane_mask; e_tmp.d = in_data;
        mq.push_back(e_tmp);
      end
    end
  end

  // Per-cycle comparison against the model, plus the register-file stand-in.
  always @(negedge clk) begin
    m_hit = 1'b0;
    foreach (mq[i]) if (mq[i].w == hz_warp && mq[i].a == hz_addr) m_hit = 1'b1;
    m_wen = (mq.size() > 0 && wb_gnt) ? mq[0].m : 8'h00;
    chk("count",    count,    mq.size());
    chk("in_ready", in_ready, (mq.size() != 4));
    chk("wb_req",   wb_req,   (mq.size() != 0));
    chk("write_en", write_en, m_wen);
    chk("hz_hit",   hz_hit,   m_hit);
    if (mq.size() > 0) begin
      chk("wb_warp", wb_warp, mq[0].w);
      chk("waddr",   waddr,   mq[0].a);
      chk("wdata",   wdata,   mq[0].d);
    end
    if (write_en != 8'h00) begin
      e_tmp.w = wb_warp; e_tmp.a = waddr; e_tmp.m = write_en; e_tmp.d = wdata;
      wlog.push_back(e_tmp);
      rf[wb_warp][waddr] = (rf[wb_warp][waddr] & ~write_en) | (wdata & write_en);
    end
  end

  initial begin
    for (int w = 0; w < 8; w++)
      for (int a = 0; a < 64; a++) rf[w][a] = 8'h00;

    // Reset state
    #12;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_wb_req",   wb_req,   0);
    chk("rst_count",    count,    0);
    chk("rst_write_en", write_en, 0);
    chk("rst_hz_hit",   hz_hit,   0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick(1);

    // Single write with grant tied high: write one cycle after acceptance, for one cycle
    wb_gnt = 1'b1;
    wlog.delete();
    push(3'd3, 6'h2A, 8'hFF, 8'hA5);
    @(negedge clk);
    chk("t1_write_en", write_en, 8'hFF);
    chk("t1_waddr",    waddr,    6'h2A);
    tick(3);
    chk("t1_nwrites", wlog.size(), 1);
    chk("t1_readback", rf[3][6'h2A], 8'hA5);

    // Backpressure: four accepted, fifth held until space opens
    wb_gnt = 1'b0;
    wlog.delete();
    for (int i = 0; i < 4; i++) push(3'(i), 6'(16 + i), 8'hFF, 8'(i * 17 + 1));
    @(negedge clk);
    chk("t2_in_ready_full", in_ready, 0);
    chk("t2_count_full",    count,    4);
    @(posedge clk); #1;
    in_valid = 1'b1; in_warp = 3'd4; in_addr = 6'd20; in_lane_mask = 8'hFF; in_data = 8'h55;
    tick(2);
    chk("t2_stalled_writes", wlog.size(), 0);
    wb_gnt = 1'b1;
    @(negedge clk);
    chk("t2_popfull_count",    count,    4);
    chk("t2_popfull_in_ready", in_ready, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t2_after_pop_count", count, 3);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("t2_pushpop_count", count, 3);
    tick(6);
    chk("t2_nwrites", wlog.size(), 5);
    for (int i = 0; i < 5; i++) if (i < wlog.size()) chk("t2_order_addr", wlog[i].a, 16 + i);
    if (wlog.size() == 5) chk("t2_fifth_data", wlog[4].d, 8'h55);

    // Eight back-to-back pushes across pointer wrap
    wlog.delete();
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_warp = 3'(i); in_addr = 6'(32 + i); in_lane_mask = 8'hFF; in_data = 8'(8'hC0 + i);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    tick(4);
    chk("t3_nwrites", wlog.size(), 8);
    for (int i = 0; i < 8; i++) if (i < wlog.size()) chk("t3_order_addr", wlog[i].a, 32 + i);

    // Partial mask over a zeroed register, then a zero-mask push
    wlog.delete();
    push(3'd2, 6'h30, 8'h0F, 8'hFF);
    tick(3);
    chk("t4_partial_readback", rf[2][6'h30], 8'h0F);
    wb_gnt = 1'b0;
    in_valid = 1'b1; in_warp = 3'd2; in_addr = 6'h31; in_lane_mask = 8'h00; in_data = 8'hFF;
    @(negedge clk);
    chk("t4_zero_mask_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("t4_zero_mask_req",   wb_req, 0);
    chk("t4_zero_mask_count", count,  0);
    chk("t4_nwrites", wlog.size(), 1);

    // Hazard lookup
    push(3'd1, 6'h05, 8'hFF, 8'h01);
    hz_warp = 3'd1; hz_addr = 6'h05;
    @(negedge clk);
    chk("t5_hit", hz_hit, 1);
    hz_warp = 3'd2; #1;
    chk("t5_warp_miss", hz_hit, 0);
    hz_warp = 3'd1; hz_addr = 6'h06; #1;
    chk("t5_addr_miss", hz_hit, 0);
    in_valid = 1'b1; in_warp = 3'd1; in_addr = 6'h07; in_lane_mask = 8'hFF; in_data = 8'h02;
    hz_addr = 6'h07; #1;
    chk("t5_inflight_push_miss", hz_hit, 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("t5_second_hit", hz_hit, 1);
    hz_addr = 6'h05; wb_gnt = 1'b1; #1;
    chk("t5_head_pop_hit", hz_hit, 1);
    @(posedge clk); #1;
    chk("t5_after_pop_miss", hz_hit, 0);
    tick(3);

    // Reset mid-stream discards queued entries with no partial write
    wb_gnt = 1'b0;
    wlog.delete();
    for (int i = 0; i < 3; i++) push(3'd5, 6'(6'h3A + i), 8'hFF, 8'h77);
    @(negedge clk);
    chk("t6_count_before", count, 3);
    #2;
    rst_n = 1'b0;
    wb_gnt = 1'b1;
    #1;
    chk("t6_wb_req",   wb_req,   0);
    chk("t6_write_en", write_en, 0);
    chk("t6_count",    count,    0);
    chk("t6_in_ready", in_ready, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick(5);
    chk("t6_no_stale_writes", wlog.size(), 0);
    push(3'd6, 6'h01, 8'hFF, 8'hC3);
    tick(3);
    chk("t6_post_reset_writes", wlog.size(), 1);
    chk("t6_post_reset_readback", rf[6][6'h01], 8'hC3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
